// File: rtl/puf_auth_controller.sv
// Host-side sequencer for the ring-oscillator PUF: measures NUM_BITS challenges one at a time,
// then either stores the response as the enrolled reference or scores it by Hamming distance.
module puf_auth_controller #(
    parameter int NUM_BITS    = 16,
    parameter int RST_CYCLES  = 4,
    parameter int WAIT_CYCLES = 10100000,
    parameter int HD_THRESH   = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                enroll_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [NUM_BITS-1:0] response_word_o,
    output logic [NUM_BITS-1:0] ref_word_o,
    output logic                ref_valid_o,
    output logic [4:0]          hamming_dist_o,
    output logic                auth_pass_o,
    output logic                no_ref_o,
    output logic                puf_rst_o,
    output logic                puf_in_valid_o,
    output logic [3:0]          puf_challange_o,
    input  logic                puf_response_bit_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRST,
        S_RUN,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_BITS - 1);
    localparam logic [31:0] RST_LOAD  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] WAIT_LOAD = 32'(WAIT_CYCLES - 1);
    localparam logic [4:0]  HD_MAX    = 5'(NUM_BITS);
    localparam logic [4:0]  HD_LIMIT  = 5'(HD_THRESH);

    state_e              state_q, state_d;
    logic [3:0]          index_q, index_d;
    logic [31:0]         wait_q, wait_d;
    logic                mode_q, mode_d;
    logic [NUM_BITS-1:0] resp_q, resp_d;
    logic [NUM_BITS-1:0] ref_q, ref_d;
    logic                ref_valid_q, ref_valid_d;
    logic [4:0]          hd_q, hd_d;
    logic                auth_pass_q, auth_pass_d;
    logic                no_ref_q, no_ref_d;

    logic                ref_bit;
    logic                hd_pass;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            index_q     <= 4'd0;
            wait_q      <= 32'd0;
            mode_q      <= 1'b0;
            resp_q      <= '0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            hd_q        <= 5'd0;
            auth_pass_q <= 1'b0;
            no_ref_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            wait_q      <= wait_d;
            mode_q      <= mode_d;
            resp_q      <= resp_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            hd_q        <= hd_d;
            auth_pass_q <= auth_pass_d;
            no_ref_q    <= no_ref_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        wait_d      = wait_q;
        mode_d      = mode_q;
        resp_d      = resp_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        hd_d        = hd_q;
        auth_pass_d = auth_pass_q;
        no_ref_d    = no_ref_q;

        ref_bit = 1'b0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (index_q == 4'(i)) begin
                ref_bit = ref_q[i];
            end
        end
        hd_pass = (hd_q <= HD_LIMIT);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d      = enroll_i;
                    index_d     = 4'd0;
                    hd_d        = 5'd0;
                    auth_pass_d = 1'b0;
                    // Authenticating with nothing enrolled is rejected without touching the PUF.
                    if (!enroll_i && !ref_valid_q) begin
                        no_ref_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        no_ref_d = 1'b0;
                        wait_d   = RST_LOAD;
                        state_d  = S_PRST;
                    end
                end
            end
            S_PRST: begin
                if (wait_q == 32'd0) begin
                    wait_d  = WAIT_LOAD;
                    state_d = S_RUN;
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            S_RUN: begin
                if (wait_q == 32'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            S_SAMPLE: begin
                for (int i = 0; i < NUM_BITS; i++) begin
                    if (index_q == 4'(i)) begin
                        resp_d[i] = puf_response_bit_i;
                    end
                end
                if (!mode_q && (puf_response_bit_i != ref_bit) && (hd_q < HD_MAX)) begin
                    hd_d = hd_q + 5'd1;
                end
                if (index_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    wait_d  = RST_LOAD;
                    state_d = S_PRST;
                end
            end
            S_DONE: begin
                if (!no_ref_q) begin
                    if (mode_q) begin
                        ref_d       = resp_q;
                        ref_valid_d = 1'b1;
                        auth_pass_d = 1'b0;
                    end else begin
                        auth_pass_d = hd_pass;
                    end
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The PUF is only released from reset while a challenge is being measured or sampled.
    always_comb begin
        busy_o          = (state_q != S_IDLE);
        done_o          = (state_q == S_DONE);
        puf_in_valid_o  = (state_q == S_RUN) || (state_q == S_SAMPLE);
        puf_rst_o       = !puf_in_valid_o;
        puf_challange_o = 4'd0;
        if ((state_q == S_PRST) || (state_q == S_RUN) || (state_q == S_SAMPLE)) begin
            puf_challange_o = index_q;
        end
        auth_pass_o = auth_pass_q;
        if ((state_q == S_DONE) && !mode_q && !no_ref_q) begin
            auth_pass_o = hd_pass;
        end
    end

    assign response_word_o = resp_q;
    assign ref_word_o      = ref_q;
    assign ref_valid_o     = ref_valid_q;
    assign hamming_dist_o  = hd_q;
    assign no_ref_o        = no_ref_q;

endmodule

// File: tb/tb_puf_auth_controller.sv
// Self-checking bench for puf_auth_controller: a cycle-count model of each run is compared
// against every output on every cycle, plus hand-derived checks of the key scenarios.
module tb_puf_auth_controller;

    localparam int N   = 4;
    localparam int R   = 2;
    localparam int W   = 5;
    localparam int HD  = 1;
    localparam int P   = R + W + 1;
    localparam int LEN = N * P + 1;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       enroll;
    logic       busy;
    logic       done;
    logic [3:0] responseWord;
    logic [3:0] refWord;
    logic       refValid;
    logic [4:0] hammingDist;
    logic       authPass;
    logic       noRef;
    logic       pufRst;
    logic       pufInValid;
    logic [3:0] pufChal;
    logic       respBit;
    logic [3:0] lut;

    always #5 clk = ~clk;

    assign respBit = pufInValid ? lut[pufChal[1:0]] : 1'b0;

    puf_auth_controller #(
        .NUM_BITS   (N),
        .RST_CYCLES (R),
        .WAIT_CYCLES(W),
        .HD_THRESH  (HD)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .start_i           (start),
        .enroll_i          (enroll),
        .busy_o            (busy),
        .done_o            (done),
        .response_word_o   (responseWord),
        .ref_word_o        (refWord),
        .ref_valid_o       (refValid),
        .hamming_dist_o    (hammingDist),
        .auth_pass_o       (authPass),
        .no_ref_o          (noRef),
        .puf_rst_o         (pufRst),
        .puf_in_valid_o    (pufInValid),
        .puf_challange_o   (pufChal),
        .puf_response_bit_i(respBit)
    );

    int nChecks = 0;
    int nFail   = 0;
    int validCount = 0;
    int doneCount  = 0;

    bit       mActive   = 0;
    int       mT        = 0;
    int       mLen      = 0;
    bit       mMode     = 0;
    bit       mNoRef    = 0;
    bit       mRefValid = 0;
    bit       mAuthPass = 0;
    logic [3:0] mResp   = 4'd0;
    logic [3:0] mRef    = 4'd0;
    int       mHd       = 0;

    bit       atDoneAuth;
    bit       atDoneNoRef;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each run is a timeline of N slots of P cycles (R in reset, W+1 valid),
    // the last valid cycle of a slot samples the bit, and the run ends with one done cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstN) begin
                mActive = 0; mT = 0; mLen = 0; mMode = 0; mNoRef = 0;
                mRefValid = 0; mAuthPass = 0; mResp = 4'd0; mRef = 4'd0; mHd = 0;
            end else if (!mActive) begin
                if (start) begin
                    mActive   = 1;
                    mT        = 1;
                    mMode     = enroll;
                    mHd       = 0;
                    mAuthPass = 0;
                    mNoRef    = !enroll && !mRefValid;
                    mLen      = mNoRef ? 1 : LEN;
                end
            end else begin
                if (!mNoRef && mT <= N * P && ((mT - 1) % P) == P - 1) begin
                    int k;
                    k = (mT - 1) / P;
                    mResp[k] = lut[k];
                    if (!mMode && lut[k] != mRef[k]) mHd++;
                end
                if (mT == mLen) begin
                    if (!mNoRef) begin
                        if (mMode) begin
                            mRef = mResp; mRefValid = 1; mAuthPass = 0;
                        end else begin
                            mAuthPass = (mHd <= HD);
                        end
                    end
                    mActive = 0;
                end else begin
                    mT++;
                end
            end
        end
    end

    initial begin
        forever begin
            bit eDone, eRst, eVal, eAuth;
            int eChal;
            @(negedge clk);
            if (pufInValid === 1'b1) validCount++;
            if (done === 1'b1) doneCount++;
            eDone = mActive && (mT == mLen);
            eRst = 1; eVal = 0; eChal = 0;
            if (mActive && !mNoRef && mT <= N * P) begin
                eRst  = ((mT - 1) % P) < R;
                eVal  = !eRst;
                eChal = (mT - 1) / P;
            end
            eAuth = mAuthPass;
            if (eDone && !mMode && !mNoRef) eAuth = (mHd <= HD);
            checkOutput("busy", 32'(busy), 32'(mActive));
            checkOutput("done", 32'(done), 32'(eDone));
            checkOutput("puf_rst", 32'(pufRst), 32'(eRst));
            checkOutput("puf_in_valid", 32'(pufInValid), 32'(eVal));
            checkOutput("puf_challange", 32'(pufChal), 32'(eChal));
            checkOutput("response_word", 32'(responseWord), 32'(mResp));
            checkOutput("ref_word", 32'(refWord), 32'(mRef));
            checkOutput("ref_valid", 32'(refValid), 32'(mRefValid));
            checkOutput("hamming_dist", 32'(hammingDist), 32'(mHd));
            checkOutput("auth_pass", 32'(authPass), 32'(eAuth));
            checkOutput("no_ref", 32'(noRef), 32'(mNoRef));
        end
    end

    // Issues one start and waits (bounded) for done; leaves the bench in the cycle after done.
    task automatic applyStimulus(input bit enr, input bit noise, output int doneCyc);
        int n;
        @(negedge clk);
        start = 1'b1;
        enroll = enr;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        doneCyc = -1;
        while (n <= 200) begin
            if (done === 1'b1) begin
                doneCyc     = n;
                atDoneAuth  = authPass;
                atDoneNoRef = noRef;
                break;
            end
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                enroll = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (doneCyc < 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 200 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        int dc;
        int vBefore;
        int dBefore;
        int gap;
        int expLen;
        rstN = 1'b0; start = 1'b0; enroll = 1'b0; lut = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_puf_rst", 32'(pufRst), 32'd1);
        checkOutput("reset_ref_valid", 32'(refValid), 32'd0);
        rstN = 1'b1;

        $display("[TB] authenticate with no reference");
        vBefore = validCount;
        applyStimulus(1'b0, 1'b0, dc);
        checkOutput("noref_done_cycle", 32'(dc), 32'd1);
        checkOutput("noref_flag", 32'(atDoneNoRef), 32'd1);
        checkOutput("noref_auth_pass", 32'(atDoneAuth), 32'd0);
        checkOutput("noref_valid_never", 32'(validCount - vBefore), 32'd0);

        $display("[TB] enroll LUT=1010");
        lut = 4'b1010;
        applyStimulus(1'b1, 1'b0, dc);
        checkOutput("enroll_done_cycle", 32'(dc), 32'd33);
        checkOutput("enroll_ref_word", 32'(refWord), 32'hA);
        checkOutput("enroll_ref_valid", 32'(refValid), 32'd1);
        checkOutput("enroll_busy_after", 32'(busy), 32'd0);

        $display("[TB] authenticate one-bit flip, start pulses while busy");
        lut = 4'b1000;
        applyStimulus(1'b0, 1'b1, dc);
        checkOutput("auth1_done_cycle", 32'(dc), 32'd33);
        checkOutput("auth1_response", 32'(responseWord), 32'h8);
        checkOutput("auth1_hd", 32'(hammingDist), 32'd1);
        checkOutput("auth1_pass_at_done", 32'(atDoneAuth), 32'd1);
        checkOutput("auth1_pass_held", 32'(authPass), 32'd1);
        dBefore = doneCount;
        repeat (40) @(negedge clk);
        checkOutput("no_extra_run", 32'(doneCount - dBefore), 32'd0);

        $display("[TB] authenticate complement");
        lut = 4'b0101;
        applyStimulus(1'b0, 1'b0, dc);
        checkOutput("auth4_hd", 32'(hammingDist), 32'd4);
        checkOutput("auth4_pass_at_done", 32'(atDoneAuth), 32'd0);

        $display("[TB] start held high across two runs");
        lut = 4'b0110;
        @(negedge clk);
        start = 1'b1; enroll = 1'b1;
        gap = 0;
        dc = 0;
        while (done !== 1'b1 && dc < 200) begin @(negedge clk); dc++; end
        @(negedge clk);
        gap = 1;
        while (done !== 1'b1 && gap < 200) begin @(negedge clk); gap++; end
        start = 1'b0;
        checkOutput("back_to_back_gap", 32'(gap), 32'(LEN + 1));
        @(negedge clk);
        checkOutput("back_to_back_ref", 32'(refWord), 32'h6);

        $display("[TB] randomized runs");
        for (int i = 0; i < 12; i++) begin
            bit enr;
            lut = 4'($urandom);
            enr = 1'($urandom_range(0, 1));
            expLen = (enr || mRefValid) ? LEN : 1;
            applyStimulus(enr, 1'b1, dc);
            checkOutput("rand_done_cycle", 32'(dc), 32'(expLen));
        end

        $display("[TB] reset during RUN of challenge 2");
        lut = 4'b1111;
        @(negedge clk);
        start = 1'b1; enroll = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        checkOutput("midrun_chal", 32'(pufChal), 32'd2);
        checkOutput("midrun_valid", 32'(pufInValid), 32'd1);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("abort_puf_rst", 32'(pufRst), 32'd1);
        checkOutput("abort_valid", 32'(pufInValid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ref_valid", 32'(refValid), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        rstN = 1'b1;
        dBefore = doneCount;
        repeat (60) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount - dBefore), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
